// File: rtl/sha256_pkg.sv
// sha256_pkg: constants shared by the SHA-256 block controller and the
// scheduler/round datapath.
//   - block geometry (ROUNDS, BLK_CNT, MSG_SIZ, CNT_W)
//   - SCHED_LAT: scheduler output latency in cycles
//   - blk_state_e: block sequencer state encoding
//   - IV: initial hash value H0..H7
//   - K: round constants, indexed by the controller's o_round_idx
package sha256_pkg;

  localparam int ROUNDS    = 64;
  localparam int BLK_CNT   = $clog2(ROUNDS);
  localparam int MSG_SIZ   = 512;
  localparam int CNT_W     = 16;
  localparam int SCHED_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCHED = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } blk_state_e;

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_const(input logic [BLK_CNT-1:0] idx);
    return K[idx];
  endfunction

endpackage

// File: rtl/sha256_rnd_cnt.sv
// sha256_rnd_cnt: word/round index counter.
// Counts 0..LAST while en is high, holds at LAST (never wraps), and returns
// to 0 on clr. tc flags cnt == LAST.
//   clk, reset   clock, asynchronous active-high reset
//   clr          synchronous clear (wins over en)
//   en           advance the index
//   cnt          current index
//   tc           terminal count (cnt == LAST)
module sha256_rnd_cnt #(
  parameter int W    = 6,
  parameter int LAST = 63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  assign tc = (cnt == LAST_V);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sha256_blk_ctrl.sv
// sha256_blk_ctrl: block-level sequencer for the SHA-256 core.
// Accepts one 512-bit block over valid/ready, walks the message scheduler
// through word indices 0..ROUNDS-1, issues round enables one cycle behind the
// scheduler, then pulses hash add and done.
//
// Optional build macro: SHA_BLK_CTRL_ABORT_EN adds i_abort / o_aborted.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_valid/o_ready   block handshake; i_first, i_msg qualified by i_valid
//   o_msg             latched block, stable from LOAD through DONE
//   o_msg_schdl_en    scheduler enable, o_blk_nmbr = scheduler word index
//   o_round_en        round enable, o_round_idx = round index (K select)
//   o_hash_init       pulse: working vars <= IV
//   o_hash_load       pulse: working vars <= chained digest
//   o_hash_add        pulse: digest += working vars
//   o_done            pulse: block finished
//   o_blk_cnt         blocks completed in current message (saturating)
//   i_abort/o_aborted abort request / one-cycle acknowledge (macro only)
//
// state  | meaning
// IDLE   | ready for a block (o_ready high once out of reset)
// LOAD   | pulse hash init (first block) or hash load (chained block)
// SCHED  | scheduler enabled, word index 0..ROUNDS-1
// DRAIN  | last scheduler word consumed by the round datapath
// FINAL  | pulse hash add
// DONE   | pulse done, block count already advanced
module sha256_blk_ctrl #(
  parameter int BLK_CNT = sha256_pkg::BLK_CNT,
  parameter int MSG_SIZ = sha256_pkg::MSG_SIZ,
  parameter int ROUNDS  = sha256_pkg::ROUNDS,
  parameter int CNT_W   = sha256_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic               i_first,
  input  logic [MSG_SIZ-1:0] i_msg,
`ifdef SHA_BLK_CTRL_ABORT_EN
  input  logic               i_abort,
  output logic               o_aborted,
`endif
  output logic               o_ready,
  output logic [MSG_SIZ-1:0] o_msg,
  output logic               o_msg_schdl_en,
  output logic [BLK_CNT-1:0] o_blk_nmbr,
  output logic               o_round_en,
  output logic [BLK_CNT-1:0] o_round_idx,
  output logic               o_hash_init,
  output logic               o_hash_load,
  output logic               o_hash_add,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_blk_cnt
);

  import sha256_pkg::*;

  blk_state_e         state, state_nxt;
  logic               ready_q;
  logic               first_q;
  logic [MSG_SIZ-1:0] msg_q;
  logic               round_en_q;
  logic [BLK_CNT-1:0] round_idx_q;
  logic [CNT_W-1:0]   blk_cnt_q;
  logic [BLK_CNT-1:0] idx;
  logic               idx_tc;
  logic               sched_en;
  logic               accept;
  logic               abort_hit;

`ifdef SHA_BLK_CTRL_ABORT_EN
  logic aborted_q;

  // Abort only matters once a block is in flight; in IDLE it is ignored so a
  // coincident i_valid is still accepted.
  assign abort_hit = i_abort && (state != ST_IDLE);
  assign o_aborted = aborted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  sha256_rnd_cnt #(
    .W    (BLK_CNT),
    .LAST (ROUNDS - 1)
  ) u_idx_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((sched_en && idx_tc) || abort_hit),
    .en    (sched_en),
    .cnt   (idx),
    .tc    (idx_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    sched_en    = 1'b0;
    o_hash_init = 1'b0;
    o_hash_load = 1'b0;
    o_hash_add  = 1'b0;
    o_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          accept    = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_hash_init = first_q;
        o_hash_load = !first_q;
        state_nxt   = ST_SCHED;
      end
      ST_SCHED: begin
        sched_en = 1'b1;
        if (idx_tc) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = ST_FINAL;
      ST_FINAL: begin
        o_hash_add = 1'b1;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  // ready is registered from the next state so it stays low while reset is
  // held and rises on the first edge after release.
  // Round enable/index trail the scheduler by its one-cycle output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      first_q     <= 1'b0;
      msg_q       <= '0;
      round_en_q  <= 1'b0;
      round_idx_q <= '0;
      blk_cnt_q   <= '0;
    end else begin
      ready_q     <= (state_nxt == ST_IDLE);
      round_en_q  <= sched_en && !abort_hit;
      round_idx_q <= (sched_en && !abort_hit) ? idx : '0;
      if (accept) begin
        msg_q   <= i_msg;
        first_q <= i_first;
      end
      // Count advances on entry to DONE so it is valid alongside o_done.
      if ((state == ST_LOAD) && first_q && !abort_hit) begin
        blk_cnt_q <= '0;
      end else if ((state_nxt == ST_DONE) && (blk_cnt_q != '1)) begin
        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_ready        = ready_q;
  assign o_msg          = msg_q;
  assign o_msg_schdl_en = sched_en;
  assign o_blk_nmbr     = idx;
  assign o_round_en     = round_en_q;
  assign o_round_idx    = round_idx_q;
  assign o_blk_cnt      = blk_cnt_q;

endmodule

// File: tb/tb_sha256_blk_ctrl.sv
`timescale 1ns/1ps
module tb_sha256_blk_ctrl;
  import sha256_pkg::*;

  localparam int MW = 512;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_first = 1'b0;
  logic [MW-1:0] i_msg = '0;
  logic          abort_drv = 1'b0;
  logic          o_aborted;
  logic          o_ready, o_msg_schdl_en, o_round_en;
  logic [MW-1:0] o_msg;
  logic [5:0]    o_blk_nmbr, o_round_idx;
  logic          o_hash_init, o_hash_load, o_hash_add, o_done;
  logic [15:0]   o_blk_cnt;

  always #5 clk = ~clk;

  sha256_blk_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_valid        (i_valid),
    .i_first        (i_first),
    .i_msg          (i_msg),
`ifdef SHA_BLK_CTRL_ABORT_EN
    .i_abort        (abort_drv),
    .o_aborted      (o_aborted),
`endif
    .o_ready        (o_ready),
    .o_msg          (o_msg),
    .o_msg_schdl_en (o_msg_schdl_en),
    .o_blk_nmbr     (o_blk_nmbr),
    .o_round_en     (o_round_en),
    .o_round_idx    (o_round_idx),
    .o_hash_init    (o_hash_init),
    .o_hash_load    (o_hash_load),
    .o_hash_add     (o_hash_add),
    .o_done         (o_done),
    .o_blk_cnt      (o_blk_cnt)
  );

`ifndef SHA_BLK_CTRL_ABORT_EN
  assign o_aborted = 1'b0;
`endif

  // Downstream scheduler + round datapath, driven only by the controller.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] hv [8];
  logic [31:0] wk [8];
  logic [31:0] wt [64];
  logic [31:0] wq;

  always @(posedge clk) begin
    logic [31:0] t1, t2, s0, s1;
    int t;
    if (o_hash_init) for (int i = 0; i < 8; i++) begin hv[i] = IV[i]; wk[i] = IV[i]; end
    if (o_hash_load) for (int i = 0; i < 8; i++) wk[i] = hv[i];
    if (o_round_en) begin
      t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25)) +
           ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[o_round_idx] + wq;
      t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22)) +
           ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
      wk[7] = wk[6]; wk[6] = wk[5]; wk[5] = wk[4]; wk[4] = wk[3] + t1;
      wk[3] = wk[2]; wk[2] = wk[1]; wk[1] = wk[0]; wk[0] = t1 + t2;
    end
    if (o_hash_add) for (int i = 0; i < 8; i++) hv[i] = hv[i] + wk[i];
    if (o_msg_schdl_en) begin
      t = int'(o_blk_nmbr);
      if (t < 16) begin
        wt[t] = o_msg[511 - 32*t -: 32];
      end else begin
        s0 = rotr(wt[t-15], 7) ^ rotr(wt[t-15], 18) ^ (wt[t-15] >> 3);
        s1 = rotr(wt[t-2], 17) ^ rotr(wt[t-2], 19) ^ (wt[t-2] >> 10);
        wt[t] = s1 + wt[t-7] + s0 + wt[t-16];
      end
      wq = wt[t];
    end
  end

  function automatic logic [255:0] digest();
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  // Checking
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  time last_done = 0;

  typedef struct {
    logic [MW-1:0] msg;
    int            cnt;
    bit            dig;
  } exp_t;
  exp_t sb[$];

  logic [18:0] act_vec;
  assign act_vec = {o_ready, o_msg_schdl_en, o_blk_nmbr, o_round_en, o_round_idx,
                    o_hash_init, o_hash_load, o_hash_add, o_done};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control vector for cycle n after the accept edge.
  function automatic logic [18:0] exp_vec(input int n, input logic first);
    logic se, re;
    logic [5:0] bn, ri;
    se = (n >= 2) && (n <= 65);
    re = (n >= 3) && (n <= 66);
    bn = se ? 6'(n - 2) : 6'd0;
    ri = re ? 6'(n - 3) : 6'd0;
    return {1'b0, se, bn, re, ri, (n == 1) && first, (n == 1) && !first, n == 67, n == 68};
  endfunction

  function automatic logic [MW-1:0] rnd_msg();
    logic [MW-1:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  task automatic run_block(input logic first, input logic [MW-1:0] msg, input bit dig,
                           input bit hold, input bit b2b, input int pulse_at, input bit abort_acc);
    int w;
    exp_t e;
    i_valid = 1'b1;
    i_first = first;
    i_msg = msg;
    if (abort_acc) abort_drv = 1'b1;
    w = 0;
    while (o_ready !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    chk("ready_before_accept", 512'(o_ready), 512'(1));
    if (b2b) chk("ready_gap_cycles", 512'(w), 512'(1));
    e.msg = msg;
    e.cnt = first ? 1 : exp_cnt + 1;
    e.dig = dig;
    exp_cnt = e.cnt;
    sb.push_back(e);
    for (int n = 1; n <= 68; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (!hold) i_valid = 1'b0;
        abort_drv = 1'b0;
        chk("msg_latched", o_msg, msg);
      end
      chk($sformatf("ctl_cycle%0d", n), 512'(act_vec), 512'(exp_vec(n, first)));
      if (n == pulse_at) begin i_valid = 1'b1; i_first = ~first; i_msg = ~msg; end
      if (n == pulse_at + 1) begin i_valid = 1'b0; i_first = first; end
      if (o_done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("blk_cnt_at_done", 512'(o_blk_cnt), 512'(e.cnt));
        chk("msg_at_done", o_msg, e.msg);
        if (e.dig) chk("digest", 512'(digest()), 512'(ABC_DIG));
        if (b2b) chk("done_spacing_ns", 512'($time - last_done), 512'(690));
        last_done = $time;
      end
    end
  endtask

  task automatic start_blk(input logic first, input logic [MW-1:0] msg);
    int w;
    i_valid = 1'b1;
    i_first = first;
    i_msg = msg;
    w = 0;
    while (o_ready !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    chk("start_ready", 512'(o_ready), 512'(1));
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic watch_quiet(input string tag, input int ncyc);
    int hits;
    hits = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_hash_add !== 1'b0 || o_ready !== 1'b1) hits++;
    end
    chk(tag, 512'(hits), 512'(0));
  endtask

  logic [MW-1:0] abc;

  initial begin
    abc = {32'h61626380, 448'h0, 32'h00000018};

    // Reset state
    #1;
    chk("rst_ctl", 512'(act_vec), 512'(0));
    chk("rst_msg", o_msg, 512'(0));
    chk("rst_cnt", 512'(o_blk_cnt), 512'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_low_at_release", 512'(o_ready), 512'(0));
    @(negedge clk);
    chk("ready_after_release", 512'(o_ready), 512'(1));

    // Single "abc" block
    run_block(1'b1, abc, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // Back-to-back with i_valid held
    run_block(1'b1, rnd_msg(), 1'b0, 1'b1, 1'b0, -1, 1'b0);
    run_block(1'b0, rnd_msg(), 1'b0, 1'b1, 1'b1, -1, 1'b0);
    run_block(1'b0, rnd_msg(), 1'b0, 1'b0, 1'b1, -1, 1'b0);

    // Stray i_valid during SCHED
    run_block(1'b0, rnd_msg(), 1'b0, 1'b0, 1'b0, 20, 1'b0);
    watch_quiet("no_extra_done", 80);

    // Asynchronous reset at cycle 30
    start_blk(1'b0, rnd_msg());
    for (int n = 2; n <= 30; n++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ctl", 512'(act_vec), 512'(0));
    chk("midrst_msg", o_msg, 512'(0));
    chk("midrst_cnt", 512'(o_blk_cnt), 512'(0));
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst_ready_low", 512'(o_ready), 512'(0));
    @(negedge clk);
    chk("midrst_ready_high", 512'(o_ready), 512'(1));
    run_block(1'b1, abc, 1'b1, 1'b0, 1'b0, -1, 1'b0);

`ifdef SHA_BLK_CTRL_ABORT_EN
    // Abort at cycle 20
    start_blk(1'b0, rnd_msg());
    for (int n = 2; n <= 20; n++) @(negedge clk);
    abort_drv = 1'b1;
    @(negedge clk);
    abort_drv = 1'b0;
    chk("aborted_pulse", 512'(o_aborted), 512'(1));
    chk("abort_idle_ctl", 512'(act_vec), 512'(19'h40000));
    @(negedge clk);
    chk("aborted_clear", 512'(o_aborted), 512'(0));
    watch_quiet("abort_quiet", 80);
    chk("abort_cnt_kept", 512'(o_blk_cnt), 512'(exp_cnt));

    // Abort coincident with accept in IDLE is ignored
    run_block(1'b1, abc, 1'b1, 1'b0, 1'b0, -1, 1'b1);
`endif

    chk("scoreboard_empty", 512'(sb.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1);
  end

endmodule
